// File: rtl/ClintStruct.sv
// Shared constants, state enums and helpers for the AXI-lite CLINT.
package ClintStruct;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {WIdle, WResp} wstate_t;
  typedef enum logic [0:0] {RIdle, RData} rstate_t;
  typedef enum logic [1:0] {SelMsip, SelMtimecmp, SelMtime, SelNone} sel_t;

  // Decodes addr[15:3]; the low three address bits never matter.
  function automatic sel_t decode(input logic [12:0] a);
    if (a == MSIP_OFF[15:3]) return SelMsip;
    if (a == MTIMECMP_OFF[15:3]) return SelMtimecmp;
    if (a == MTIME_OFF[15:3]) return SelMtime;
    return SelNone;
  endfunction

  function automatic logic [63:0] byte_merge(input logic [63:0] cur, input logic [63:0] wdata,
                                             input logic [7:0] strb);
    logic [63:0] res;
    res = cur;
    for (int i = 0; i < 8; i++) begin
      if (strb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// Prescaled 64-bit mtime counter with a strobed write port and a registered mtip compare.
module clint_timer
  import ClintStruct::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [63:0] wr_data,
  input  logic [7:0]  wr_strb,
  input  logic [63:0] mtimecmp_next,
  output logic [63:0] mtime,
  output logic        mtip
);

  if ((TICK_DIV < 1) || (TICK_DIV > 65535)) begin : g_tick_div_check
    $error("TICK_DIV must be in 1..65535");
  end

  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        mtip_q;
  logic        tick;

  assign tick = (presc_q == 16'(TICK_DIV - 1));

  // A bus write wins over the tick and restarts the prescale period.
  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_en) begin
      presc_d = 16'd0;
      mtime_d = byte_merge(mtime_q, wr_data, wr_strb);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 16'd0;
      mtime_q <= 64'd0;
      mtip_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
      mtip_q  <= (mtime_d >= mtimecmp_next);
    end
  end

  assign mtime = mtime_q;
  assign mtip  = mtip_q;

endmodule

// File: rtl/axi_lite_clint.sv
// AXI-lite CLINT responder: write/read FSMs, decoder, msip and mtimecmp.
// Define CLINT_SLVERR_EN to answer unmapped offsets with SLVERR instead of OKAY.
module axi_lite_clint
  import ClintStruct::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [7:0]            s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  mtip,
  output logic                  msip
);

  if (DATA_WIDTH != 64) begin : g_data_width_check
    $error("DATA_WIDTH must be 64");
  end

`ifdef CLINT_SLVERR_EN
  localparam logic [1:0] UnmappedResp = RESP_SLVERR;
`else
  localparam logic [1:0] UnmappedResp = RESP_OKAY;
`endif

  wstate_t     wstate_q;
  rstate_t     rstate_q;
  logic        awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [63:0] rdata_q;
  logic        aw_held_q, w_held_q;
  logic [12:0] awaddr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [63:0] mtime;

  logic        aw_hs, w_hs, ar_hs, do_write, mtime_wr;
  logic [12:0] wr_addr;
  logic [63:0] wr_data, rd_val;
  logic [7:0]  wr_strb;
  logic [1:0]  wr_resp, rd_resp;
  sel_t        wr_sel, rd_sel;
  logic        unused_addr;

  assign unused_addr = ^{s_awaddr, s_araddr};

  // Readies are only ever high in the idle state with nothing held.
  assign aw_hs = s_awvalid & awready_q;
  assign w_hs  = s_wvalid & wready_q;
  assign ar_hs = s_arvalid & arready_q;

  assign wr_addr  = aw_hs ? s_awaddr[15:3] : awaddr_q;
  assign wr_data  = w_hs ? 64'(s_wdata) : wdata_q;
  assign wr_strb  = w_hs ? s_wstrb : wstrb_q;
  assign do_write = (wstate_q == WIdle) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
  assign wr_sel   = decode(wr_addr);
  assign rd_sel   = decode(s_araddr[15:3]);
  assign wr_resp  = (wr_sel == SelNone) ? UnmappedResp : RESP_OKAY;
  assign rd_resp  = (rd_sel == SelNone) ? UnmappedResp : RESP_OKAY;
  assign mtime_wr = do_write & (wr_sel == SelMtime) & (|wr_strb);

  always_comb begin
    unique case (rd_sel)
      SelMsip:     rd_val = {63'd0, msip_q};
      SelMtimecmp: rd_val = mtimecmp_q;
      SelMtime:    rd_val = mtime;
      default:     rd_val = 64'd0;
    endcase
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (do_write && wr_sel == SelMtimecmp) mtimecmp_d = byte_merge(mtimecmp_q, wr_data, wr_strb);
    if (do_write && wr_sel == SelMsip && wr_strb[0]) msip_d = wr_data[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
    end else begin
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate_q  <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= 13'd0;
      wdata_q   <= 64'd0;
      wstrb_q   <= 8'd0;
    end else begin
      case (wstate_q)
        WIdle: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= s_awaddr[15:3];
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= s_wdata;
            wstrb_q  <= s_wstrb;
          end
          if (do_write) begin
            wstate_q  <= WResp;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= ~(aw_held_q | aw_hs);
            wready_q  <= ~(w_held_q | w_hs);
          end
        end
        WResp: begin
          if (s_bready) begin
            wstate_q  <= WIdle;
            bvalid_q  <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate_q  <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 64'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rstate_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            rstate_q  <= RData;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= rd_resp;
          end
        end
        RData: begin
          if (s_rready) begin
            rstate_q  <= RIdle;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rstate_q <= RIdle;
      endcase
    end
  end

  clint_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (mtime_wr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .mtimecmp_next (mtimecmp_d),
    .mtime         (mtime),
    .mtip          (mtip)
  );

  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = DATA_WIDTH'(rdata_q);
  assign s_rresp   = rresp_q;
  assign msip      = msip_q;

endmodule

// File: tb/tb_axi_lite_clint.sv
// Scoreboard bench for axi_lite_clint: mtime modelled in closed form from the last write.
module tb_axi_lite_clint;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_awaddr, s_araddr, s_wdata, s_rdata;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic        s_arvalid, s_arready, s_rvalid, s_rready, mtip, msip;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;

  always #5 clk = ~clk;

  axi_lite_clint dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .mtip      (mtip),
    .msip      (msip)
  );

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    int          due;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  s;
  } wbeat_t;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        rq[$];
  exp_t        bq[$];
  logic [63:0] awq[$];
  wbeat_t      wq[$];
  bit          b_hold = 1'b0;
  bit          rnd_ready = 1'b0;

  // Reference state: mtime(k) = m_base + (k - m_base_cyc), one tick per clock.
  logic [63:0] m_base, m_cmp;
  int          m_base_cyc;
  logic        m_msip;
  bit          m_live = 1'b0;
  logic [63:0] m_a;
  wbeat_t      m_w;
  exp_t        m_e;
  bit          r_shown, b_shown;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_event(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: got %s, required none at cycle %0d", name, what, cyc);
  endtask

  function automatic logic [63:0] mtime_at(input int k);
    return m_base + 64'(k - m_base_cyc);
  endfunction

  function automatic logic [15:0] off_of(input logic [63:0] a);
    return {a[15:3], 3'b000};
  endfunction

  function automatic logic [1:0] exp_resp(input logic [63:0] a);
    logic [15:0] off;
    off = off_of(a);
    if (off == 16'h0000 || off == 16'h4000 || off == 16'hBFF8) return 2'b00;
`ifdef CLINT_SLVERR_EN
    return 2'b10;
`else
    return 2'b00;
`endif
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] d,
                                        input logic [7:0] s);
    logic [63:0] r;
    r = cur;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] exp_read(input logic [63:0] a, input int k);
    logic [15:0] off;
    off = off_of(a);
    if (off == 16'h0000) return {63'd0, m_msip};
    if (off == 16'h4000) return m_cmp;
    if (off == 16'hBFF8) return mtime_at(k);
    return 64'd0;
  endfunction

  task automatic apply_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                             input int k);
    logic [15:0] off;
    off = off_of(a);
    if (s == 8'h00) return;
    if (off == 16'h0000) begin
      if (s[0]) m_msip = d[0];
    end else if (off == 16'h4000) begin
      m_cmp = merge(m_cmp, d, s);
    end else if (off == 16'hBFF8) begin
      m_base     = merge(mtime_at(k), d, s);
      m_base_cyc = k + 1;
    end
  endtask

  // Model side: checks level outputs, then turns observed handshakes into expectations.
  always @(negedge clk) begin
    if (rst) begin
      m_base = 64'd0;
      m_base_cyc = cyc + 1;
      m_cmp = '1;
      m_msip = 1'b0;
      m_live = 1'b1;
      awq.delete();
      wq.delete();
      rq.delete();
      bq.delete();
    end else if (m_live) begin
      check("mtip", 64'(mtip), 64'(mtime_at(cyc) >= m_cmp));
      check("msip", 64'(msip), 64'(m_msip));
      if (s_arvalid && s_arready) begin
        m_e = '{data: exp_read(s_araddr, cyc), resp: exp_resp(s_araddr), due: cyc + 1};
        rq.push_back(m_e);
      end
      if (s_awvalid && s_awready) awq.push_back(s_awaddr);
      if (s_wvalid && s_wready) begin
        m_w = '{d: s_wdata, s: s_wstrb};
        wq.push_back(m_w);
      end
      if (awq.size() > 0 && wq.size() > 0) begin
        m_a = awq.pop_front();
        m_w = wq.pop_front();
        apply_write(m_a, m_w.d, m_w.s, cyc);
        m_e = '{data: 64'd0, resp: exp_resp(m_a), due: cyc + 1};
        bq.push_back(m_e);
      end
    end
  end

  // Monitor side: compares every presented R/B beat with the queue head.
  always @(negedge clk) begin
    if (rst) begin
      r_shown = 1'b0;
      b_shown = 1'b0;
    end else begin
      if (s_rvalid) begin
        if (rq.size() == 0) begin
          fail_event("r_unexpected", "rvalid");
        end else begin
          if (!r_shown) check("r_latency", 64'(cyc), 64'(rq[0].due));
          check("rdata", s_rdata, rq[0].data);
          check("rresp", 64'(s_rresp), 64'(rq[0].resp));
          r_shown = 1'b1;
          if (s_rready) begin
            void'(rq.pop_front());
            r_shown = 1'b0;
          end
        end
      end
      if (s_bvalid) begin
        check("ready_during_b", 64'({s_awready, s_wready}), 64'd0);
        if (bq.size() == 0) begin
          fail_event("b_unexpected", "bvalid");
        end else begin
          if (!b_shown) check("b_latency", 64'(cyc), 64'(bq[0].due));
          check("bresp", 64'(s_bresp), 64'(bq[0].resp));
          b_shown = 1'b1;
          if (s_bready) begin
            void'(bq.pop_front());
            b_shown = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    s_bready = 1'b1;
    s_rready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      s_bready = b_hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
      s_rready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Drivers start and end just after a rising edge.
  task automatic send_aw(input logic [63:0] a, input int lead);
    int n;
    repeat (lead) begin
      @(posedge clk);
      #1;
    end
    s_awaddr = a;
    s_awvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_awready) break;
      if (++n > 200) begin
        fail_event("aw_timeout", "no awready in 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] s, input int lead);
    int n;
    repeat (lead) begin
      @(posedge clk);
      #1;
    end
    s_wdata = d;
    s_wstrb = s;
    s_wvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_wready) break;
      if (++n > 200) begin
        fail_event("w_timeout", "no wready in 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [63:0] a, input int lead);
    int n;
    repeat (lead) begin
      @(posedge clk);
      #1;
    end
    s_araddr = a;
    s_arvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (s_arready) break;
      if (++n > 200) begin
        fail_event("ar_timeout", "no arready in 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int aw_lead, input int w_lead);
    fork
      send_aw(a, aw_lead);
      send_w(d, s, w_lead);
    join
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [63:0] rand_addr();
    logic [63:0] a;
    logic [15:0] off;
    case ($urandom_range(0, 4))
      0:       off = 16'h0000;
      1:       off = 16'h4000;
      2, 3:    off = 16'hBFF8;
      default: off = 16'($urandom_range(0, 65535));
    endcase
    a = {$urandom, $urandom};
    a[15:0] = off;
    a[2:0] = 3'($urandom_range(0, 7));
    return a;
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    {s_awvalid, s_wvalid, s_arvalid} = '0;
    s_awaddr = '0;
    s_araddr = '0;
    s_wdata = '0;
    s_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send_ar(64'h4000, 0);
    // W leads AW by three cycles; mtip should rise once mtime passes 0x20.
    do_write(64'h4000, 64'h20, 8'hFF, 3, 0);
    idle(40);
    do_write(64'hBFF8, 64'h0, 8'hFF, 0, 0);
    do_write(64'hBFF8, 64'h1122_3344_5566_7788, 8'h0F, 0, 0);
    send_ar(64'hBFF8, 0);
    do_write(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0);
    send_ar(64'hBFF8, 0);

    // Stalled B: a second write must wait for the B handshake.
    b_hold = 1'b1;
    do_write(64'h4000, 64'hFFFF_FFFF_0000_0000, 8'hFF, 0, 0);
    fork
      do_write(64'h0000, 64'h3, 8'hFF, 1, 0);
      begin
        idle(5);
        b_hold = 1'b0;
      end
    join
    send_ar(64'h0004, 0);
    do_write(64'h0000, 64'h0, 8'hFF, 0, 0);
    send_ar(64'h0000, 0);
    send_ar(64'h1000, 0);
    do_write(64'h1000, 64'hDEAD_BEEF, 8'hFF, 0, 1);
    send_ar(64'h1000, 0);
    idle(4);

    rnd_ready = 1'b1;
    fork
      for (int i = 0; i < 80; i++) begin
        logic [63:0] a, d;
        logic [7:0]  s;
        a = rand_addr();
        d = {$urandom, $urandom};
        s = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        if (off_of(a) == 16'h4000) d = mtime_at(cyc) + 64'($urandom_range(0, 30));
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2));
      end
      for (int i = 0; i < 80; i++) send_ar(rand_addr(), $urandom_range(0, 2));
    join
    rnd_ready = 1'b0;
    n = 0;
    while ((rq.size() + bq.size()) != 0 && n < 100) begin
      idle(1);
      n++;
    end
    check("drain", 64'(rq.size() + bq.size()), 64'd0);

    // Reset while a response is pending: it must vanish and state returns to defaults.
    b_hold = 1'b1;
    do_write(64'h4000, 64'h5, 8'hFF, 0, 0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    b_hold = 1'b0;
    idle(5);
    send_ar(64'h4000, 0);
    idle(5);
    check("final_drain", 64'(rq.size() + bq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
